// File: rtl/vga_square_cfg_if.sv
// Request bus between the square-config requesters and the config scheduler.
// Requester r drives req[r], the target square id at req_id[2r+1:2r], and
// x/y/size at [r*COORD_W +: COORD_W]. The scheduler returns a one-hot gnt.
// A transfer happens on every clock edge where gnt[r] is high.
//   master : requester side (drives req*, samples gnt)
//   slave  : scheduler side (samples req*, drives gnt)
interface vga_square_cfg_if #(
    parameter int COORD_W = 10
);
    logic [2:0]           req;
    logic [5:0]           req_id;
    logic [3*COORD_W-1:0] req_x;
    logic [3*COORD_W-1:0] req_y;
    logic [3*COORD_W-1:0] req_s;
    logic [2:0]           gnt;

    modport master (
        output req, req_id, req_x, req_y, req_s,
        input  gnt
    );

    modport slave (
        input  req, req_id, req_x, req_y, req_s,
        output gnt
    );
endinterface

// File: rtl/vga_square_cfg_ctrl.sv
// Configuration scheduler for the three-square VGA renderer.
// Three requesters are arbitrated round-robin into a pending bank; pending
// entries marked dirty are copied to the active bank only on frame_start
// (start of vertical blanking) so the renderer never sees a torn frame.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   frame_start     one-cycle pulse at the start of vertical blanking
//   freeze          skip commits while high (pending data kept)
//   req_if          request bus (slave side), combinational one-hot grant
//   act_x/y/s       active config, square k at [k*COORD_W +: COORD_W]
//   dirty           per-square pending-awaiting-commit flag
//   commit          one-cycle pulse when new active values appear
//   bad_id          one-cycle pulse after a granted request targeted id 3
module vga_square_cfg_ctrl #(
    parameter int                     COORD_W  = 10,
    parameter int                     H_ACTIVE = 640,
    parameter int                     V_ACTIVE = 480,
    parameter logic [3*COORD_W-1:0]   RST_X    = {10'd250, 10'd150, 10'd50},
    parameter logic [3*COORD_W-1:0]   RST_Y    = {10'd250, 10'd150, 10'd50},
    parameter logic [3*COORD_W-1:0]   RST_S    = {10'd150, 10'd150, 10'd150}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 freeze,
    vga_square_cfg_if.slave      req_if,
    output logic [3*COORD_W-1:0] act_x,
    output logic [3*COORD_W-1:0] act_y,
    output logic [3*COORD_W-1:0] act_s,
    output logic [2:0]           dirty,
    output logic                 commit,
    output logic                 bad_id
);

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_ACTIVE);

    logic [1:0]                rr_q, rr_d;
    logic [2:0][COORD_W-1:0]   pend_x_q, pend_x_d;
    logic [2:0][COORD_W-1:0]   pend_y_q, pend_y_d;
    logic [2:0][COORD_W-1:0]   pend_s_q, pend_s_d;
    logic [2:0][COORD_W-1:0]   act_x_q, act_x_d;
    logic [2:0][COORD_W-1:0]   act_y_q, act_y_d;
    logic [2:0][COORD_W-1:0]   act_s_q, act_s_d;
    logic [2:0]                dirty_q, dirty_d;
    logic                      commit_q, commit_d;
    logic                      bad_id_q, bad_id_d;

    // Arbitration / write path
    logic                      wr;
    logic [1:0]                sel;
    logic [1:0]                cand;
    logic [1:0]                wr_id;
    logic [COORD_W-1:0]        in_x, in_y, in_s;
    logic [COORD_W-1:0]        cl_x, cl_y, cl_s;
    logic [COORD_W:0]          sum_x, sum_y;
    logic                      do_commit;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Round-robin search starting at rr_q; first requester found wins.
    always_comb begin
        wr   = 1'b0;
        sel  = 2'd0;
        cand = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!wr && req_if.req[cand]) begin
                wr  = 1'b1;
                sel = cand;
            end
            cand = inc3(cand);
        end
        if (rst) wr = 1'b0;
        req_if.gnt = wr ? (3'b001 << sel) : 3'b000;
    end

    // Mux the winner's fields and clamp so the square stays on screen.
    // Sums are one bit wider so x+s cannot wrap before the compare.
    always_comb begin
        wr_id = req_if.req_id[sel*2 +: 2];
        in_x  = req_if.req_x[sel*COORD_W +: COORD_W];
        in_y  = req_if.req_y[sel*COORD_W +: COORD_W];
        in_s  = req_if.req_s[sel*COORD_W +: COORD_W];
        cl_s  = (in_s > V_MAX) ? V_MAX : in_s;
        sum_x = {1'b0, in_x} + {1'b0, cl_s};
        sum_y = {1'b0, in_y} + {1'b0, cl_s};
        cl_x  = (sum_x > {1'b0, H_MAX}) ? H_MAX - cl_s : in_x;
        cl_y  = (sum_y > {1'b0, V_MAX}) ? V_MAX - cl_s : in_y;
    end

    always_comb begin
        rr_d     = rr_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        pend_s_d = pend_s_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        act_s_d  = act_s_q;
        dirty_d  = dirty_q;
        bad_id_d = 1'b0;

        do_commit = frame_start && !freeze && (dirty_q != 3'b000);
        commit_d  = do_commit;

        // Commit reads pre-edge pending values; a write on the same edge is
        // applied afterwards so it re-marks its square dirty for next frame.
        if (do_commit) begin
            for (int k = 0; k < 3; k++) begin
                if (dirty_q[k]) begin
                    act_x_d[k] = pend_x_q[k];
                    act_y_d[k] = pend_y_q[k];
                    act_s_d[k] = pend_s_q[k];
                    dirty_d[k] = 1'b0;
                end
            end
        end

        if (wr) begin
            rr_d = inc3(sel);
            if (wr_id == 2'd3) begin
                bad_id_d = 1'b1;
            end else begin
                pend_x_d[wr_id] = cl_x;
                pend_y_d[wr_id] = cl_y;
                pend_s_d[wr_id] = cl_s;
                dirty_d[wr_id]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= 2'd0;
            pend_x_q <= RST_X;
            pend_y_q <= RST_Y;
            pend_s_q <= RST_S;
            act_x_q  <= RST_X;
            act_y_q  <= RST_Y;
            act_s_q  <= RST_S;
            dirty_q  <= 3'b000;
            commit_q <= 1'b0;
            bad_id_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            pend_s_q <= pend_s_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            act_s_q  <= act_s_d;
            dirty_q  <= dirty_d;
            commit_q <= commit_d;
            bad_id_q <= bad_id_d;
        end
    end

    assign act_x  = act_x_q;
    assign act_y  = act_y_q;
    assign act_s  = act_s_q;
    assign dirty  = dirty_q;
    assign commit = commit_q;
    assign bad_id = bad_id_q;

endmodule

// File: doc/vga_square_cfg_ctrl.md
# vga_square_cfg_ctrl

Configuration scheduler for the three-square VGA renderer. It accepts position/size update requests from three independent requesters (e.g. key handler, switch handler, demo sequencer) and arbitrates them round-robin into a pending register bank. Updates are committed atomically to the active bank only at the start of vertical blanking, so the renderer never draws a torn frame. The active bank drives the renderer's per-square x/y/size inputs directly.

## Interface

- `COORD_W`, 10, width of every coordinate and size field (unsigned)
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `RST_X`, {10'd250,10'd150,10'd50}, reset x per square (sq2,sq1,sq0 packed)
- `RST_Y`, {10'd250,10'd150,10'd50}, reset y per square
- `RST_S`, {10'd150,10'd150,10'd150}, reset size per square

- `clk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse from the timing generator at vcount==V_ACTIVE, hcount==0
- `freeze`  in  1  when high, commits are skipped and pending data is retained
- `req`  in  3  per-requester request, held until granted
- `req_id`  in  6  2-bit target square per requester (requester r at [2r+1:2r])
- `req_x`, `req_y`, `req_s`  in  3*COORD_W each  requested x, y, size per requester
- `gnt`  out  3  one-hot grant, combinational, same cycle as transfer
- `act_x`, `act_y`, `act_s`  out  3*COORD_W each  active (committed) config, square k at [k*COORD_W +: COORD_W]
- `dirty`  out  3  per-square flag: pending differs from active and is awaiting commit
- `commit`  out  1  registered pulse, high the cycle the new active values first appear
- `bad_id`  out  1  registered pulse: a granted request targeted square id 3

## Operation

- Arbitration: round-robin pointer `rr` (0..2). Search starts at `rr`, then `rr+1`, `rr+2` (mod 3). The first requester with `req` high gets `gnt`. At most one grant per cycle. After a grant to r, `rr` <= (r+1) mod 3. With no request, `rr` holds.
- `gnt` is forced to 0 while `rst` is high.
- A transfer occurs on every edge where `gnt[r]`=1. The requester drops or changes `req` in the following cycle.
- Clamping is applied on write, with 11-bit intermediate sums:
  - s' = min(req_s, V_ACTIVE)
  - x' = (x+s' > H_ACTIVE) ? H_ACTIVE−s' : x
  - y' = (y+s' > V_ACTIVE) ? V_ACTIVE−s' : y
  - size 0 is legal and means the square is disabled.
- Write: pending[id] <= {x',y',s'} and dirty[id] <= 1. For id==3, no register changes and `bad_id` pulses next cycle. Multiple writes before a commit: last wins.
- Commit: on an edge with frame_start=1 and freeze=0, and only when dirty≠0:
  - active[k] <= pending[k] for each k with dirty[k]=1
  - those dirty bits clear
  - `commit` <= 1
- With frame_start=1 and dirty==0, `commit` stays 0.
- Simultaneous write and commit in the same cycle:
  - the commit uses pending values from before the edge
  - the written square ends with the new pending value and dirty=1, taking effect next frame
  - other squares commit normally
- freeze=1 at frame_start: nothing commits, dirty is preserved, `commit`=0. Writes still accepted.

## Timing

- Reset (edge with rst=1):
  - active = pending = RST_*
  - dirty=0, rr=0, commit=0, bad_id=0
- Reset mid-operation discards pending writes; any in-flight request is not granted that cycle.
- Grant latency: 0 cycles (combinational).
- Write-to-pending: 1 edge.
- Write-to-active: the next frame_start edge at or after the cycle following the write edge.
- `commit` and `bad_id` are high for exactly one cycle.
- Worst-case grant wait under continuous contention is 2 cycles.

## Test plan

- Reset, then idle: act_x={250,150,50}, act_s all 150, dirty=0, gnt=0; frame_start produces no commit.
- Requester 1 writes sq0 (x=100, y=60, s=80), then frame_start: dirty=3'b001 until the frame_start edge; then act sq0=(100,60,80), commit=1 for one cycle, dirty=0.
- All three req held high from rr=0: gnt sequence 001, 010, 100, 001; each requester is granted once in any 3 consecutive cycles.
- Clamp: write sq2 x=600, y=470, s=500 -> pending (160, 0, 480); write s=0 is accepted and disables sq2.
- Write sq1 in the same cycle as frame_start while sq0 is dirty: sq0 commits now; sq1 stays dirty and commits at the next frame_start. With freeze=1 there, nothing commits.
- req_id=3 granted: no state change, bad_id pulses one cycle, rr advances.
